// File: rtl/pzbcm_sram_pkg.sv
// Shared SRAM configuration type and sizing helpers for the pzbcm SRAM
// macro wrapper and the FIFO controller built on top of it.
//   pzbcm_sram_params      : SRAM macro configuration record
//   get_ram_pointer_width  : address width for a given word count
//   get_fifo_buffer_depth  : prefetch buffer depth of the SRAM FIFO
//   get_fifo_count_width   : occupancy counter width of the SRAM FIFO
package pzbcm_sram_pkg;

    typedef struct packed {
        int words;
        int data_width;
        bit single_port_ram;
        bit dual_clock;
        int read_latency;
        int id;
    } pzbcm_sram_params;

    localparam pzbcm_sram_params PZBCM_SRAM_DEFAULT_PARAMS = '{
        words:           16,
        data_width:      32,
        single_port_ram: 1'b0,
        dual_clock:      1'b0,
        read_latency:    1,
        id:              0
    };

    function automatic int get_ram_pointer_width(pzbcm_sram_params params);
        return (params.words > 1) ? $clog2(params.words) : 1;
    endfunction

    // One slot per read that can be in the SRAM pipeline plus one for the
    // head entry being presented on the pop side.
    function automatic int get_fifo_buffer_depth(pzbcm_sram_params params);
        return params.read_latency + 1;
    endfunction

    // Must represent words + buffer depth (= words + read_latency + 1).
    function automatic int get_fifo_count_width(pzbcm_sram_params params);
        return $clog2(params.words + params.read_latency + 2);
    endfunction

endpackage

// File: rtl/pzbcm_sram_fifo_read_buffer.sv
// Small register FIFO holding SRAM read data in front of the pop interface.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_clear           : synchronous flush (priority over push/pop)
//   i_push, i_push_data : write one entry
//   i_pop             : remove head entry (must only be asserted when o_valid)
//   o_valid, o_data   : head entry present / head entry data
//   o_count           : number of entries held
module pzbcm_sram_fifo_read_buffer
    import pzbcm_sram_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    // Depth is generally not a power of two, so pointers wrap explicitly.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(i_push) - CW'(i_pop);
        if (i_push) begin
            tail_d = (tail_q == IW'(DEPTH - 1)) ? '0 : tail_q + IW'(1);
        end
        if (i_pop) begin
            head_d = (head_q == IW'(DEPTH - 1)) ? '0 : head_q + IW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[tail_q] <= i_push_data;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[head_q];
    assign o_count = count_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear) begin
            assert (!(i_pop && (count_q == '0)));
            assert (!(i_push && !i_pop && (count_q == CW'(DEPTH))));
        end
    end

endmodule

// File: rtl/pzbcm_sram_fifo_ctrl.sv
// Synchronous FIFO controller storing its entries in an external simple
// dual-port SRAM. A (read_latency+1)-entry prefetch buffer hides the SRAM
// read latency so the pop side runs at full throughput.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_clear                : synchronous flush, same effect as reset
//   i_push_valid/o_push_ready/i_push_data : push stream
//   o_pop_valid/i_pop_ready/o_pop_data    : pop stream
//   o_sram_write, o_sram_write_pointer, o_sram_write_data : SRAM write port
//   o_sram_read, o_sram_read_pointer, i_sram_read_data    : SRAM read port
//   o_empty, o_full, o_word_count : occupancy status
module pzbcm_sram_fifo_ctrl
    import pzbcm_sram_pkg::*;
#(
    parameter  pzbcm_sram_params SRAM_PARAMS = PZBCM_SRAM_DEFAULT_PARAMS,
    localparam int W  = SRAM_PARAMS.words,
    localparam int D  = SRAM_PARAMS.data_width,
    localparam int L  = SRAM_PARAMS.read_latency,
    localparam int B  = get_fifo_buffer_depth(SRAM_PARAMS),
    localparam int PW = get_ram_pointer_width(SRAM_PARAMS),
    localparam int CW = get_fifo_count_width(SRAM_PARAMS)
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  logic [D-1:0]  i_push_data,
    output logic          o_pop_valid,
    input  logic          i_pop_ready,
    output logic [D-1:0]  o_pop_data,
    output logic          o_sram_write,
    output logic [PW-1:0] o_sram_write_pointer,
    output logic [D-1:0]  o_sram_write_data,
    output logic          o_sram_read,
    output logic [PW-1:0] o_sram_read_pointer,
    input  logic [D-1:0]  i_sram_read_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_word_count
);

    localparam int BCW = $clog2(B + 1);

    logic          flush;
    logic          push_ready;
    logic          push_fire;
    logic          pop_fire;
    logic          read_issue;
    logic          buf_valid;
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] sram_count_q, sram_count_d;
    logic [L-1:0]  inflight_q, inflight_d;
    logic [CW-1:0] inflight_cnt;
    logic [BCW-1:0] buf_count;
    logic [CW-1:0] buf_count_cw;
    logic [CW-1:0] word_count;

    assign flush        = i_rst | i_clear;
    assign push_ready   = (sram_count_q < CW'(W));
    assign push_fire    = i_push_valid & push_ready;
    assign pop_fire     = buf_valid & i_pop_ready;
    assign buf_count_cw = CW'(buf_count);

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < L; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
        end
    end

    // A read is issued only if its data is sure to find a free buffer slot,
    // counting the slot freed by a pop in this same cycle.
    assign read_issue = (sram_count_q != '0) &&
                        ((buf_count_cw + inflight_cnt) < (CW'(B) + CW'(pop_fire)));

    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        sram_count_d = sram_count_q + CW'(push_fire) - CW'(read_issue);
        inflight_d   = (inflight_q << 1) | L'(read_issue);
        if (push_fire) begin
            wp_d = (wp_q == PW'(W - 1)) ? '0 : wp_q + PW'(1);
        end
        if (read_issue) begin
            rp_d = (rp_q == PW'(W - 1)) ? '0 : rp_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wp_q         <= '0;
            rp_q         <= '0;
            sram_count_q <= '0;
            inflight_q   <= '0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            sram_count_q <= sram_count_d;
            inflight_q   <= inflight_d;
        end
    end

    pzbcm_sram_fifo_read_buffer #(
        .DEPTH (B),
        .WIDTH (D)
    ) u_read_buffer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_push      (inflight_q[L-1]),
        .i_push_data (i_sram_read_data),
        .i_pop       (pop_fire),
        .o_valid     (buf_valid),
        .o_data      (o_pop_data),
        .o_count     (buf_count)
    );

    assign word_count = sram_count_q + inflight_cnt + buf_count_cw;

    assign o_push_ready         = push_ready;
    assign o_full               = !push_ready;
    assign o_pop_valid          = buf_valid;
    assign o_sram_write         = push_fire;
    assign o_sram_write_pointer = wp_q;
    assign o_sram_write_data    = i_push_data;
    assign o_sram_read          = read_issue;
    assign o_sram_read_pointer  = rp_q;
    assign o_empty              = (word_count == '0);
    assign o_word_count         = word_count;

    always_ff @(posedge i_clk) begin
        assert (W >= 2 && L >= 1 && !SRAM_PARAMS.single_port_ram && !SRAM_PARAMS.dual_clock);
        if (!flush) begin
            assert ((buf_count_cw + inflight_cnt) <= CW'(B));
            assert (!(pop_fire && !buf_valid));
        end
    end

endmodule

// File: tb/tb_pzbcm_sram_fifo_ctrl.sv
// Directed + randomized bench for pzbcm_sram_fifo_ctrl (W=8, D=16, L=2, B=3)
// with a behavioural SRAM model and a queue scoreboard.
module tb_pzbcm_sram_fifo_ctrl;
    import pzbcm_sram_pkg::*;

    localparam pzbcm_sram_params TB_PARAMS = '{
        words:           8,
        data_width:      16,
        single_port_ram: 1'b0,
        dual_clock:      1'b0,
        read_latency:    2,
        id:              0
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_data;
    logic        pop_valid;
    logic        pop_ready;
    logic [15:0] pop_data;
    logic        sram_write;
    logic [2:0]  sram_write_pointer;
    logic [15:0] sram_write_data;
    logic        sram_read;
    logic [2:0]  sram_read_pointer;
    logic [15:0] sram_read_data;
    logic        empty;
    logic        full;
    logic [3:0]  word_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] model_q [$];

    always #5 clk = ~clk;

    pzbcm_sram_fifo_ctrl #(
        .SRAM_PARAMS (TB_PARAMS)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_clear              (clear),
        .i_push_valid         (push_valid),
        .o_push_ready         (push_ready),
        .i_push_data          (push_data),
        .o_pop_valid          (pop_valid),
        .i_pop_ready          (pop_ready),
        .o_pop_data           (pop_data),
        .o_sram_write         (sram_write),
        .o_sram_write_pointer (sram_write_pointer),
        .o_sram_write_data    (sram_write_data),
        .o_sram_read          (sram_read),
        .o_sram_read_pointer  (sram_read_pointer),
        .i_sram_read_data     (sram_read_data),
        .o_empty              (empty),
        .o_full               (full),
        .o_word_count         (word_count)
    );

    // SRAM macro model with a two-cycle read pipeline.
    logic [15:0] sram_mem [8];
    logic [15:0] rd_pipe [2];
    always @(posedge clk) begin
        if (sram_write) sram_mem[sram_write_pointer] <= sram_write_data;
        if (sram_read) rd_pipe[0] <= sram_mem[sram_read_pointer];
        rd_pipe[1] <= rd_pipe[0];
    end
    assign sram_read_data = rd_pipe[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [15:0] pd, input logic pr);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
    endtask

    // Scoreboard checks for the current cycle, then advance one clock.
    task automatic cyc();
        if (!rst) begin
            chk("word_count", 32'(word_count), 32'(model_q.size()));
            chk("buf_bound", 32'((int'(dut.buf_count) + int'(dut.inflight_cnt)) <= 3), 32'(1));
            if (pop_valid && pop_ready) begin
                if (model_q.size() == 0) chk("pop_nonempty", 32'(0), 32'(1));
                else chk("pop_data", 32'(pop_data), 32'(model_q.pop_front()));
            end
            if (push_valid && push_ready) model_q.push_back(push_data);
        end
        if (rst || clear) model_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'(1));
        chk({tag, "_full"}, 32'(full), 32'(0));
        chk({tag, "_count"}, 32'(word_count), 32'(0));
        chk({tag, "_push_ready"}, 32'(push_ready), 32'(1));
        chk({tag, "_pop_valid"}, 32'(pop_valid), 32'(0));
        chk({tag, "_sram_write"}, 32'(sram_write), 32'(0));
        chk({tag, "_sram_read"}, 32'(sram_read), 32'(0));
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        repeat (2) cyc();
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        chk_idle("reset");

        // Single push: write at c0, read at c1, pop_valid at c4.
        drive(1'b1, 16'h1234, 1'b0);
        chk("single_wr", 32'(sram_write), 32'(1));
        chk("single_wptr", 32'(sram_write_pointer), 32'(0));
        chk("single_wdata", 32'(sram_write_data), 32'h1234);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("single_rd", 32'(sram_read), 32'(1));
        chk("single_rptr", 32'(sram_read_pointer), 32'(0));
        chk("single_c1_valid", 32'(pop_valid), 32'(0));
        cyc();
        chk("single_c2_valid", 32'(pop_valid), 32'(0));
        chk("single_c2_rd", 32'(sram_read), 32'(0));
        cyc();
        chk("single_c3_valid", 32'(pop_valid), 32'(0));
        cyc();
        chk("single_c4_valid", 32'(pop_valid), 32'(1));
        chk("single_c4_data", 32'(pop_data), 32'h1234);
        drive(1'b0, 16'h0, 1'b1);
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("single_after_empty", 32'(empty), 32'(1));
        chk("single_after_valid", 32'(pop_valid), 32'(0));

        // Fill with no pops: 11 accepted, 12th held off.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 16'(16'h100 + i), 1'b0);
            chk("fill_push_ready", 32'(push_ready), 32'(i < 11));
            chk("fill_sram_write", 32'(sram_write), 32'(i < 11));
            if (i < 11) chk("fill_wptr", 32'(sram_write_pointer), 32'((1 + i) % 8));
            cyc();
        end
        drive(1'b1, 16'h10B, 1'b1);
        chk("full_flag", 32'(full), 32'(1));
        chk("full_count", 32'(word_count), 32'(11));
        chk("full_no_write", 32'(sram_write), 32'(0));
        chk("full_pop_rd", 32'(sram_read), 32'(1));
        chk("full_pop_data", 32'(pop_data), 32'h100);
        cyc();
        drive(1'b1, 16'h10B, 1'b0);
        chk("refill_ready", 32'(push_ready), 32'(1));
        chk("refill_write", 32'(sram_write), 32'(1));
        chk("refill_wptr", 32'(sram_write_pointer), 32'(4));
        cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("refull_flag", 32'(full), 32'(1));
        chk("refull_count", 32'(word_count), 32'(11));
        drive(1'b0, 16'h0, 1'b1);
        for (int n = 0; n < 40 && word_count != 4'd0; n++) cyc();
        drive(1'b0, 16'h0, 1'b0);
        chk("drain_empty", 32'(empty), 32'(1));
        chk("drain_model", 32'(model_q.size()), 32'(0));

        // Clear resets pointers; outputs match the reset state.
        clear = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        cyc();
        clear = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        chk_idle("clear");

        // Streaming: one push and one pop per cycle with pointer wrap.
        for (int k = 0; k < 105; k++) begin
            drive(k < 100, 16'(k), 1'b1);
            if (k < 100) begin
                chk("stream_write", 32'(sram_write), 32'(1));
                chk("stream_wptr", 32'(sram_write_pointer), 32'(k % 8));
            end
            if (k >= 1 && k <= 100) begin
                chk("stream_read", 32'(sram_read), 32'(1));
                chk("stream_rptr", 32'(sram_read_pointer), 32'((k - 1) % 8));
            end
            if (k >= 4 && k <= 103) begin
                chk("stream_valid", 32'(pop_valid), 32'(1));
                chk("stream_data", 32'(pop_data), 32'(k - 4));
            end
            cyc();
        end
        drive(1'b0, 16'h0, 1'b0);
        chk("stream_empty", 32'(empty), 32'(1));

        // Clear while two reads are in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'hA0 + i), 1'b0);
            cyc();
        end
        clear = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        chk("preclear_count", 32'(word_count), 32'(3));
        chk("preclear_inflight", 32'(dut.inflight_cnt), 32'(2));
        cyc();
        clear = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("postclear_count", 32'(word_count), 32'(0));
            chk("postclear_empty", 32'(empty), 32'(1));
            chk("postclear_valid", 32'(pop_valid), 32'(0));
            cyc();
        end

        // Random traffic against the scoreboard.
        for (int n = 0; n < 2000; n++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pzbcm_sram_fifo_ctrl.md
Name: pzbcm_sram_fifo_ctrl

Overview:
- Synchronous FIFO controller that keeps its storage in an external simple-dual-port SRAM macro described by a pzbcm_sram_params value.
- Handles write/read pointers, the SRAM read latency, and a small register prefetch buffer, so the pop side sees a normal valid/ready stream at full throughput.
- Sits directly upstream of the SRAM macro wrapper: it drives that wrapper's write and read ports and consumes its read data.

Parameters:
- SRAM_PARAMS, '{words: 16, data_width: 32, single_port_ram: 0, dual_clock: 0, read_latency: 1, id: 0}, SRAM configuration. Requires words ≥ 2, read_latency ≥ 1, single_port_ram = 0, dual_clock = 0.
- W, SRAM_PARAMS.words, derived (localparam).
- D, SRAM_PARAMS.data_width, derived (localparam).
- L, SRAM_PARAMS.read_latency, derived (localparam).
- B, L+1, prefetch buffer depth (localparam).
- PW, get_ram_pointer_width(SRAM_PARAMS), SRAM pointer width (localparam).
- CW, $clog2(W+B+1), occupancy count width (localparam).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_clear  in  1  synchronous flush, same effect as reset on all state
- i_push_valid  in  1  push request
- o_push_ready  out  1  push accepted when valid & ready
- i_push_data  in  D  push data
- o_pop_valid  out  1  head entry valid
- i_pop_ready  in  1  pop request
- o_pop_data  out  D  head entry data
- o_sram_write  out  1  SRAM write strobe
- o_sram_write_pointer  out  PW  SRAM write address
- o_sram_write_data  out  D  SRAM write data
- o_sram_read  out  1  SRAM read strobe
- o_sram_read_pointer  out  PW  SRAM read address
- i_sram_read_data  in  D  read data, valid L cycles after o_sram_read
- o_empty  out  1  word_count == 0
- o_full  out  1  !o_push_ready
- o_word_count  out  CW  total entries held = sram_count + inflight + buf_count

Behaviour:
- Reset and clear: wp = 0, rp = 0, sram_count = 0, inflight shift register = 0, buffer empty.
  - Resulting outputs: o_pop_valid = 0, o_empty = 1, o_full = 0, o_word_count = 0, o_push_ready = 1.
  - i_clear has priority over push and pop in the same cycle.
- Push fire = i_push_valid & o_push_ready.
  - o_push_ready = (sram_count < W), from registered state only.
  - On fire: o_sram_write = 1 the same cycle, with o_sram_write_pointer = wp and o_sram_write_data = i_push_data (combinational pass-through); then wp increments.
- Pointer wrap: wp and rp go from W-1 to 0. W need not be a power of two.
- Pop fire = o_pop_valid & i_pop_ready.
  - o_pop_valid = buffer non-empty; o_pop_data = buffer head (registered).
- Read issue: o_sram_read = (sram_count > 0) & (buf_count + inflight_count - pop_fire < B).
  - o_sram_read_pointer = rp; rp increments on issue.
  - An address written in cycle t is read no earlier than t+1, so no read-during-write hazard.
- sram_count updates by +push_fire - read_issue. Both in the same cycle leaves it unchanged.
- Inflight tracking: an L-bit shift register; bit 0 is set on issue.
  - When the bit at stage L-1 is set, i_sram_read_data is written into the buffer.
  - inflight_count is the popcount of the shift register.
  - Clear or reset zeroes the shift register, so data returned for pre-clear reads is discarded.
- Buffer never overflows; this is guaranteed by the read-issue rule and checked by an assertion.
- Latency: push in cycle t gives o_pop_valid in cycle t+2+L when the FIFO was empty.
- Steady state: one push and one pop per cycle, no bubbles.
- Capacity = W+B entries.
  - With no pops, o_full asserts after W+B pushes (B entries are prefetched into the buffer).
  - With pops, o_full is observed only once sram_count == W.
- Push while full: held off, no SRAM write. Pop while empty: ignored.
- Assertions: no pop_fire when the buffer is empty; buf_count + inflight_count ≤ B; the parameter legality requirements above.

Decomposition:
- Add to pzbcm_sram_pkg:
  - get_fifo_buffer_depth(params) = read_latency+1
  - get_fifo_count_width(params) = $clog2(words+read_latency+2)
  - Reuse get_ram_pointer_width for PW.
- Sub-module pzbcm_sram_fifo_read_buffer: B-entry register FIFO with push, pop, count, and flush.

Test Plan (W=8, D=16, L=2, B=3):
- Reset -> o_empty=1, o_full=0, o_word_count=0, o_push_ready=1, o_pop_valid=0, no SRAM strobes; same after i_clear.
- Single push 0x1234 at cycle 0 -> write ptr 0 at cycle 0, read ptr 0 at cycle 1, o_pop_valid=1 with 0x1234 at cycle 4.
- 12 pushes with i_pop_ready=0 -> first 11 accepted, o_full=1 and o_word_count=11 afterwards, 12th held. Popping one word re-enables push after the next read issue.
- 100 consecutive push/pop cycles with data 0..99 -> pops in order, no bubbles after cycle 4, both pointers wrap 7→0 repeatedly.
- i_clear asserted with 2 reads inflight -> next cycle o_word_count=0 and o_empty=1; returning data discarded, o_pop_valid stays 0.
- Random push_valid and pop_ready at 50% for 2000 cycles -> scoreboard order match, buf_count + inflight_count ≤ 3 always, o_word_count matches the model.
